// File: rtl/gt_refclk_div_pkg.sv
// gt_clk_pkg: shared definitions for the GT reference-clock divider slice.
// Contents: divide-code width, CE synchronizer depth limits, divider state
// encoding and the high-phase length helper.
package gt_clk_pkg;

   localparam int unsigned DIV_W       = 3;
   localparam int unsigned CE_SYNC_MIN = 2;
   localparam int unsigned CE_SYNC_MAX = 4;

   typedef enum logic {
      ST_STOPPED = 1'b0,
      ST_RUN     = 1'b1
   } state_t;

   // High cycles per output period: H = (N+1)>>1 with N = div+1.
   function automatic logic [DIV_W:0] high_cycles(input logic [DIV_W-1:0] div);
      return ({1'b0, div} + (DIV_W+1)'(2)) >> 1;
   endfunction

endpackage

// File: rtl/gt_refclk_div_if.sv
// gt_refclk_div_if: control/status bundle of the reference-clock divider.
//   CE         enable request, asynchronous to the reference clock
//   CEMASK     forces the effective enable high
//   DIV        requested divide code (N = DIV+1)
//   O          divided clock
//   RUNNING    divider is in its run state
//   DIV_ACTIVE divide code currently applied
// master: the controlling side; slave: the divider.
interface gt_refclk_div_if;
   import gt_clk_pkg::*;

   logic             CE;
   logic             CEMASK;
   logic [DIV_W-1:0] DIV;
   logic             O;
   logic             RUNNING;
   logic [DIV_W-1:0] DIV_ACTIVE;

   modport master (output CE, CEMASK, DIV, input O, RUNNING, DIV_ACTIVE);
   modport slave  (input CE, CEMASK, DIV, output O, RUNNING, DIV_ACTIVE);

endinterface

// File: rtl/gt_refclk_div_sync.sv
// gt_sync_bit: STAGES-deep single-bit synchronizer with asynchronous
// active-low clear.
//   clk   destination clock
//   clr_n asynchronous active-low clear (all stages to 0)
//   d     asynchronous input
//   q     synchronized output (last stage)
module gt_sync_bit #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic clr_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync;

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) sync <= '0;
      else        sync <= {sync[STAGES-2:0], d};
   end

   assign q = sync[STAGES-1];

endmodule

// File: rtl/gt_refclk_div.sv
// gt_refclk_div: glitch-free programmable divider (N = 1..8) for the GT
// reference clock.
//   I     reference clock; all state on rising edge, divide-by-1 gate on
//         falling edge
//   CLRB  asynchronous active-low reset
//   bus   control/status (CE, CEMASK, DIV in; O, RUNNING, DIV_ACTIVE out)
// Start/stop and ratio changes happen only on period boundaries so O never
// produces a runt pulse (reset excepted).
module gt_refclk_div
   import gt_clk_pkg::*;
#(
   parameter int unsigned CE_SYNC_STAGES = 2
) (
   input  logic             I,
   input  logic             CLRB,
   gt_refclk_div_if.slave   bus
);

   if (CE_SYNC_STAGES < CE_SYNC_MIN || CE_SYNC_STAGES > CE_SYNC_MAX) begin : g_bad_stages
      $error("gt_refclk_div: CE_SYNC_STAGES must be within 2..4");
   end

   logic             ce_sync;
   logic             ce_eff;
   state_t           state, state_nx;
   logic [DIV_W-1:0] cnt, cnt_nx;
   logic [DIV_W-1:0] div_q, div_nx;
   logic             o_q, o_nx;
   logic             gate_n;
   logic             wrap;
   logic [DIV_W:0]   high;

   gt_sync_bit #(.STAGES(CE_SYNC_STAGES)) u_ce_sync (
      .clk   (I),
      .clr_n (CLRB),
      .d     (bus.CE),
      .q     (ce_sync)
   );

   assign ce_eff = bus.CEMASK | ce_sync;
   assign high   = high_cycles(div_q);
   assign wrap   = (cnt == div_q);

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      div_nx   = div_q;
      o_nx     = o_q;
      case (state)
         ST_STOPPED: begin
            cnt_nx = '0;
            o_nx   = 1'b0;
            if (ce_eff) begin
               state_nx = ST_RUN;
               div_nx   = bus.DIV;
               o_nx     = 1'b1;
            end
         end
         ST_RUN: begin
            if (wrap) begin
               cnt_nx = '0;
               if (ce_eff) begin
                  div_nx = bus.DIV;
                  o_nx   = 1'b1;
               end else begin
                  state_nx = ST_STOPPED;
                  o_nx     = 1'b0;
               end
            end else begin
               cnt_nx = cnt + DIV_W'(1);
               o_nx   = (({1'b0, cnt} + (DIV_W+1)'(1)) < high);
            end
         end
         default: state_nx = ST_STOPPED;
      endcase
   end

   always_ff @(posedge I or negedge CLRB) begin
      if (!CLRB) begin
         state <= ST_STOPPED;
         cnt   <= '0;
         div_q <= '0;
         o_q   <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         div_q <= div_nx;
         o_q   <= o_nx;
      end
   end

   // Divide-by-1 gate: updated while I is low, so it only ever admits or
   // blocks complete high phases of I.
   always_ff @(negedge I or negedge CLRB) begin
      if (!CLRB) gate_n <= 1'b0;
      else       gate_n <= (state == ST_RUN);
   end

   assign bus.O          = (div_q != '0) ? o_q : (I & gate_n);
   assign bus.RUNNING    = (state == ST_RUN);
   assign bus.DIV_ACTIVE = div_q;

endmodule
